// File: rtl/dmux4_pkg.sv
// Shared types and helpers for the 4-way dispatch sequencer.
package dmux4_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {IDLE, HOLD} state_e;

  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
    return ptr + 2'd1;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first preferred sink from ptr, else first eligible.
module rr_pick4
  import dmux4_pkg::*;
(
  input  logic [SEL_W-1:0]  ptr,
  input  logic [NUM_CH-1:0] eligible,
  input  logic [NUM_CH-1:0] preferred,
  output logic [SEL_W-1:0]  pick,
  output logic              found
);

  logic [SEL_W-1:0] p_pick, e_pick, idx;
  logic             p_found, e_found;

  always_comb begin
    p_pick  = ptr;
    e_pick  = ptr;
    p_found = 1'b0;
    e_found = 1'b0;
    idx     = ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + SEL_W'(k);
      if (!p_found && preferred[idx]) begin
        p_pick  = idx;
        p_found = 1'b1;
      end
      if (!e_found && eligible[idx]) begin
        e_pick  = idx;
        e_found = 1'b1;
      end
    end
  end

  assign pick  = p_found ? p_pick : e_pick;
  assign found = p_found | e_found;

endmodule

// File: rtl/dmux4_dispatch_ctrl.sv
// One-word holding register dispatching round-robin to four sinks.
// Optional per-sink delivery counters under DMUX4_STATS_EN.
module dmux4_dispatch_ctrl
  import dmux4_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_data,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic [SEL_W-1:0]    out_sel
`ifdef DMUX4_STATS_EN
  , output logic [NUM_CH*CNT_W-1:0] dlv_cnt
`endif
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d, sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] pick_ptr, pick;
  logic             pick_found;
  logic             deliver, accept;

  assign out_valid = (state_q == HOLD) ? (NUM_CH'(1) << sel_q) : '0;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  assign deliver  = (state_q == HOLD) & out_ready[sel_q];
  // pick_found is exactly |ch_en, so a word is only taken when a sink exists
  assign in_ready = ((state_q == IDLE) | deliver) & pick_found;
  assign accept   = in_valid & in_ready;

  // Back-to-back accept searches from the sink after the one just served
  assign pick_ptr = deliver ? rr_next(sel_q) : ptr_q;

  rr_pick4 u_pick (
    .ptr       (pick_ptr),
    .eligible  (ch_en),
    .preferred (ch_en & out_ready),
    .pick      (pick),
    .found     (pick_found)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    if (deliver) begin
      ptr_d   = rr_next(sel_q);
      state_d = IDLE;
    end
    if (accept) begin
      state_d = HOLD;
      sel_d   = pick;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

`ifdef DMUX4_STATS_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (deliver && (cnt_q[sel_q] != {CNT_W{1'b1}})) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 1'b1;
    end
  end

  assign dlv_cnt = cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
